// File: rtl/kmeans_pkg.sv
// Shared k-means definitions: default sizes, update-block state encoding and
// the Q32.32 unit constant.
package kmeans_pkg;

    localparam int K    = 10;
    localparam int W    = 64;
    localparam int FRAC = 32;
    localparam int CW   = 32;

    localparam logic signed [W-1:0] ONE = W'(1) << FRAC;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DIV   = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/centroid_div.sv
// Sequential restoring divider: signed dividend by unsigned divisor, truncated
// toward zero, with a fixed W-cycle latency from start to the done pulse.
module centroid_div #(
    parameter int W  = kmeans_pkg::W,
    parameter int CW = kmeans_pkg::CW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [W-1:0] dividend,
    input  logic [CW-1:0]       divisor,
    output logic                done,
    output logic signed [W-1:0] quotient
);

    localparam int NW = $clog2(W + 1);

    logic [W-1:0]    acc;
    logic [CW-1:0]   rem;
    logic [CW-1:0]   dvs;
    logic            neg;
    logic            busy;
    logic [NW-1:0]   cnt;
    logic [W-1:0]    mag;
    logic [CW+W-1:0] step_p0;

    // One restoring step: the quotient bit shifts into acc as the dividend
    // bits shift out; the remainder always stays below the divisor.
    function automatic logic [CW+W-1:0] div_step(input logic [CW-1:0] r,
                                                 input logic [W-1:0]  a,
                                                 input logic [CW-1:0] d);
        logic [CW:0] trial;
        logic [CW:0] diff;
        trial = {r, a[W-1]};
        diff  = trial - {1'b0, d};
        if (trial >= {1'b0, d})
            return {diff[CW-1:0], a[W-2:0], 1'b1};
        return {trial[CW-1:0], a[W-2:0], 1'b0};
    endfunction

    function automatic logic signed [W-1:0] apply_sign(input logic [W-1:0] m,
                                                       input logic         n);
        return n ? -$signed(m) : $signed(m);
    endfunction

    assign mag = dividend[W-1] ? -dividend : dividend;

    // The load cycle already performs the first step, so W steps fit in W cycles.
    assign step_p0 = start ? div_step('0, mag, divisor) : div_step(rem, acc, dvs);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                cnt  <= NW'(W - 1);
            end else if (busy) begin
                cnt <= cnt - 1'b1;
                if (cnt == NW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            {rem, acc} <= step_p0;
            dvs        <= divisor;
            neg        <= dividend[W-1];
        end else if (busy) begin
            {rem, acc} <= step_p0;
            if (cnt == NW'(1))
                quotient <= apply_sign(step_p0[W-1:0], neg);
        end
    end

endmodule

// File: rtl/centroid_update.sv
// k-means update step: accumulates (point, index) beats into per-cluster sums
// and counts, then on flush divides and streams out the new centroids 0..K-1.
module centroid_update #(
    parameter int K  = kmeans_pkg::K,
    parameter int W  = kmeans_pkg::W,
    parameter int CW = kmeans_pkg::CW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                io_in_valid,
    output logic                io_in_ready,
    input  logic signed [W-1:0] io_in_x,
    input  logic signed [W-1:0] io_in_y,
    input  logic [31:0]         io_in_idx,
    input  logic                io_flush,
    output logic                io_busy,
    output logic                io_err,
    output logic                io_out_valid,
    input  logic                io_out_ready,
    output logic [31:0]         io_out_idx,
    output logic signed [W-1:0] io_out_x,
    output logic signed [W-1:0] io_out_y,
    output logic                io_out_empty
);

    import kmeans_pkg::*;

    localparam int PW = $clog2(K);

    state_t              state, state_nx;
    logic [PW-1:0]       ptr;
    logic signed [W-1:0] sum_x [K];
    logic signed [W-1:0] sum_y [K];
    logic [CW-1:0]       count [K];

    logic                div_start, div_active, div_done;
    logic                done_x, done_y;
    logic signed [W-1:0] q_x, q_y;
    logic                idx_ok, in_fire, out_fire, last, cur_empty;
    logic [PW-1:0]       in_slot;

    assign idx_ok    = io_in_idx < 32'(K);
    assign in_slot   = io_in_idx[PW-1:0];
    assign in_fire   = io_in_valid && io_in_ready;
    assign out_fire  = io_out_valid && io_out_ready;
    assign last      = ptr == PW'(K - 1);
    assign div_done  = done_x && done_y;
    assign cur_empty = count[ptr] == '0;

    always_comb begin
        state_nx     = state;
        io_in_ready  = 1'b0;
        io_busy      = 1'b0;
        io_out_valid = 1'b0;
        div_start    = 1'b0;
        case (state)
            ACCUM: begin
                io_in_ready = 1'b1;
                if (io_flush)
                    state_nx = DIV;
            end
            DIV: begin
                io_busy   = 1'b1;
                div_start = !div_active;
                if (div_done)
                    state_nx = EMIT;
            end
            EMIT: begin
                io_busy      = 1'b1;
                io_out_valid = 1'b1;
                if (io_out_ready)
                    state_nx = last ? ACCUM : DIV;
            end
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACCUM;
            ptr        <= '0;
            div_active <= 1'b0;
            io_err     <= 1'b0;
        end else begin
            state <= state_nx;
            if (div_start)
                div_active <= 1'b1;
            else if (div_done)
                div_active <= 1'b0;
            if (in_fire && !idx_ok)
                io_err <= 1'b1;
            if (state == ACCUM && io_flush)
                ptr <= '0;
            else if (out_fire)
                ptr <= last ? '0 : ptr + 1'b1;
        end
    end

    // Accumulation and per-cluster clear are exclusive: one happens in ACCUM,
    // the other only on an EMIT handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < K; i++) begin
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                count[i] <= '0;
            end
        end else if (in_fire && idx_ok) begin
            sum_x[in_slot] <= sum_x[in_slot] + io_in_x;
            sum_y[in_slot] <= sum_y[in_slot] + io_in_y;
            count[in_slot] <= count[in_slot] + CW'(1);
        end else if (out_fire) begin
            sum_x[ptr] <= '0;
            sum_y[ptr] <= '0;
            count[ptr] <= '0;
        end
    end

    centroid_div #(.W(W), .CW(CW)) u_div_x (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (sum_x[ptr]),
        .divisor  (count[ptr]),
        .done     (done_x),
        .quotient (q_x)
    );

    centroid_div #(.W(W), .CW(CW)) u_div_y (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (sum_y[ptr]),
        .divisor  (count[ptr]),
        .done     (done_y),
        .quotient (q_y)
    );

    // Output beat is captured once on entry to EMIT and held until handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_out_idx   <= '0;
            io_out_x     <= '0;
            io_out_y     <= '0;
            io_out_empty <= 1'b0;
        end else if (state == DIV && div_done) begin
            io_out_idx   <= 32'(ptr);
            io_out_x     <= cur_empty ? '0 : q_x;
            io_out_y     <= cur_empty ? '0 : q_y;
            io_out_empty <= cur_empty;
        end
    end

endmodule

// File: tb/tb_centroid_update.sv
// Directed bench for centroid_update: hand-computed centroids, per-beat latency,
// bad index, back-pressure, flush with a same-cycle beat and reset mid-pass.
module tb_centroid_update;

    import kmeans_pkg::*;

    localparam int NK = 10;
    localparam int LAT = 65;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_x, in_y;
    logic [31:0] in_idx;
    logic        flush;
    logic        busy;
    logic        err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_idx;
    logic [63:0] out_x, out_y;
    logic        out_empty;

    int n_chk = 0;
    int n_pass = 0;

    longint      m_sx [NK];
    longint      m_sy [NK];
    int unsigned m_cnt [NK];
    logic [63:0] got_x [NK];
    logic [63:0] got_y [NK];

    longint q1;

    always #5 clk = ~clk;

    centroid_update dut (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (in_valid),
        .io_in_ready  (in_ready),
        .io_in_x      (in_x),
        .io_in_y      (in_y),
        .io_in_idx    (in_idx),
        .io_flush     (flush),
        .io_busy      (busy),
        .io_err       (err),
        .io_out_valid (out_valid),
        .io_out_ready (out_ready),
        .io_out_idx   (out_idx),
        .io_out_x     (out_x),
        .io_out_y     (out_y),
        .io_out_empty (out_empty)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NK; i++) begin
            m_sx[i] = 0;
            m_sy[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic send(input longint x, input longint y, input int unsigned idx);
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        in_idx = idx;
        tick();
        in_valid = 1'b0;
        if (idx < NK) begin
            m_sx[idx] += x;
            m_sy[idx] += y;
            m_cnt[idx]++;
        end
    endtask

    task automatic do_flush(input bit beat, input longint x, input longint y, input int unsigned idx);
        flush = 1'b1;
        in_valid = beat;
        in_x = x;
        in_y = y;
        in_idx = idx;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        if (beat && idx < NK) begin
            m_sx[idx] += x;
            m_sy[idx] += y;
            m_cnt[idx]++;
        end
    endtask

    // Accept n_beats beats; beat bp_idx is held off for 20 cycles first.
    task automatic collect(input int n_beats, input int bp_idx);
        int cyc;
        logic [63:0] ex_x, ex_y, h_x, h_y;
        logic [31:0] h_idx;
        bit stable;
        for (int k = 0; k < n_beats; k++) begin
            cyc = 0;
            while (!out_valid && cyc < 200) begin
                tick();
                cyc++;
            end
            if (!out_valid) begin
                chk($sformatf("beat%0d_timeout", k), 64'd0, 64'd1);
                return;
            end
            chk($sformatf("lat%0d", k), 64'(cyc), 64'(LAT));
            ex_x = (m_cnt[k] == 0) ? 64'd0 : 64'(m_sx[k] / longint'(m_cnt[k]));
            ex_y = (m_cnt[k] == 0) ? 64'd0 : 64'(m_sy[k] / longint'(m_cnt[k]));
            chk($sformatf("idx%0d", k), 64'(out_idx), 64'(k));
            chk($sformatf("x%0d", k), out_x, ex_x);
            chk($sformatf("y%0d", k), out_y, ex_y);
            chk($sformatf("empty%0d", k), 64'(out_empty), 64'(m_cnt[k] == 0));
            got_x[k] = out_x;
            got_y[k] = out_y;
            if (k == bp_idx) begin
                out_ready = 1'b0;
                h_idx = out_idx;
                h_x = out_x;
                h_y = out_y;
                stable = 1'b1;
                repeat (20) begin
                    tick();
                    if (!out_valid || out_idx != h_idx || out_x != h_x || out_y != h_y)
                        stable = 1'b0;
                end
                chk("bp_hold", 64'(stable), 64'd1);
                out_ready = 1'b1;
            end
            tick();
            m_sx[k] = 0;
            m_sy[k] = 0;
            m_cnt[k] = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        q1 = longint'(ONE);
        reset = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        in_idx = '0;
        flush = 1'b0;
        out_ready = 1'b1;
        model_clear();
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_x", out_x, 64'd0);
        chk("rst_out_y", out_y, 64'd0);
        chk("rst_out_empty", 64'(out_empty), 64'd0);

        // Mean of two points.
        send(q1, 2 * q1, 0);
        send(3 * q1, 4 * q1, 0);
        do_flush(1'b0, 0, 0, 0);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_in_ready", 64'(in_ready), 64'd0);
        collect(NK, -1);
        chk("t1_x0", got_x[0], 64'h0000000200000000);
        chk("t1_y0", got_y[0], 64'h0000000300000000);
        chk("t1_x1", got_x[1], 64'h0);

        // Signed truncation toward zero.
        send(-q1, 0, 3);
        send(-2 * q1, 0, 3);
        send(-4 * q1, 0, 3);
        do_flush(1'b0, 0, 0, 0);
        collect(NK, -1);
        chk("t2_x3", got_x[3], 64'hFFFFFFFDAAAAAAAB);
        chk("t2_y3", got_y[3], 64'h0);

        // Bad index plus back-pressure at beat 2.
        send(q1, q1, 1);
        chk("t3_err_before", 64'(err), 64'd0);
        send(9 * q1, 9 * q1, 10);
        chk("t3_err_set", 64'(err), 64'd1);
        send(3 * q1, 3 * q1, 1);
        do_flush(1'b0, 0, 0, 0);
        collect(NK, 2);
        chk("t3_x1", got_x[1], 64'h0000000200000000);
        chk("t3_y1", got_y[1], 64'h0000000200000000);
        chk("t3_err_held", 64'(err), 64'd1);

        // Flush with a beat in the same cycle, then an all-empty pass.
        do_flush(1'b1, 5 * q1, 5 * q1, 7);
        collect(NK, -1);
        chk("t4_x7", got_x[7], 64'h0000000500000000);
        chk("t4_y7", got_y[7], 64'h0000000500000000);
        chk("t4_in_ready", 64'(in_ready), 64'd1);
        do_flush(1'b0, 0, 0, 0);
        collect(NK, -1);

        // Reset while cluster 4 is dividing.
        send(q1, q1, 4);
        do_flush(1'b0, 0, 0, 0);
        collect(4, -1);
        repeat (30) tick();
        chk("t5_busy_pre", 64'(busy), 64'd1);
        chk("t5_err_pre", 64'(err), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        chk("t5_err", 64'(err), 64'd0);
        model_clear();
        do_flush(1'b0, 0, 0, 0);
        collect(NK, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/centroid_update.md
Name: centroid_update

Overview:
- Performs the k-means update step that consumes the assignment stream produced by the closest-centroid block.
- Input stream: (point, closest index). Accepted points are accumulated into per-cluster coordinate sums and counts.
- On flush, each cluster's sum is divided by its count and the new centroids are emitted in order, 0..K-1, over a valid/ready stream.
- Coordinates are signed Q32.32 fixed point, so the block is synthesizable.

Parameters:
- K, 10, number of clusters; legal indices are 0..K-1.
- W, 64, coordinate and sum width (two's complement, Q(W-FRAC).FRAC).
- FRAC, 32, fractional bits; informational only, since division is by an integer count.
- CW, 32, per-cluster count width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- io_in_valid  in  1  point/index beat valid
- io_in_ready  out  1  block can accept a beat
- io_in_x  in  W  point x
- io_in_y  in  W  point y
- io_in_idx  in  32  closest-centroid index
- io_flush  in  1  end of pass; start the divide/emit phase
- io_busy  out  1  high while in DIV or EMIT
- io_err  out  1  sticky flag: an index >= K was received
- io_out_valid  out  1  centroid beat valid
- io_out_ready  in  1  consumer accepts the beat
- io_out_idx  out  32  cluster index of the beat
- io_out_x  out  W  new centroid x
- io_out_y  out  W  new centroid y
- io_out_empty  out  1  cluster had count 0; x and y are forced to 0

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset clears all sums, counts, cluster pointer and io_err, and forces state to ACCUM.
  - Reset values: io_in_ready=1, io_busy=0, io_err=0, io_out_valid=0, io_out_idx/x/y=0, io_out_empty=0.
  - Reset mid-DIV or mid-EMIT abandons the pass; no beat is emitted.
- States: ACCUM, DIV, EMIT.
- ACCUM:
  - io_in_ready=1.
  - On in_valid with idx<K: sum_x[idx]+=x, sum_y[idx]+=y (modulo 2^W), count[idx]+=1 (modulo 2^CW).
  - Idx>=K: beat consumed and discarded; io_err set and held until reset.
  - io_flush=1 moves to DIV with ptr=0. A valid beat in the same cycle as io_flush is accumulated first.
- DIV:
  - io_in_ready=0. io_flush is ignored in DIV and EMIT.
  - Start both dividers on sum_x[ptr]/count[ptr] and sum_y[ptr]/count[ptr].
  - Quotients are ready after exactly W cycles, then go to EMIT.
- EMIT:
  - io_out_valid=1; idx/x/y/empty are held stable until io_out_ready.
  - If count==0: x=y=0 and empty=1; the divider result is ignored.
  - On handshake: clear sum/count[ptr]. If ptr==K-1, go to ACCUM; else ptr+=1 and go to DIV.
- Division: signed dividend / unsigned count, truncated toward zero. Result width is W; it cannot overflow because |q| <= |sum|.
- Latency:
  - The first out_valid is asserted W+1 cycles after the cycle in which flush is sampled.
  - Each subsequent beat is W+1 cycles after the previous handshake.
  - io_out_ready held high gives a pass length of K*(W+1) cycles.
- Back-pressure: out_valid is never dropped before handshake, and outputs never change while valid && !ready.

Decomposition:
- Shared package (kmeans_pkg):
  - K, W, FRAC, CW defaults.
  - State enum {ACCUM, DIV, EMIT}.
  - Q32.32 helper constant ONE = 1<<FRAC.
- Sub-module centroid_div: sequential restoring divider, W-cycle fixed latency.
  - Inputs: start, signed dividend[W], unsigned divisor[CW].
  - Outputs: done pulse, quotient[W].
  - Sign is handled by magnitude division and negate.
  - Two instances: x and y.

Test Plan:
- Mean of two points: points (1.0,2.0) and (3.0,4.0) to idx 0 (1.0=0x0000000100000000), then flush with out_ready=1 -> beat idx0 x=0x0000000200000000 y=0x0000000300000000 empty=0, first valid W+1=65 cycles after flush. Beats idx1..9 have empty=1, x=y=0.
- Signed truncation: x=-1.0,-2.0,-4.0 to idx 3 (y=0) -> idx3 x = -7.0/3 truncated toward zero = 0xFFFFFFFDAAAAAAAB. Bit-exact check against a model.
- Bad index: beat with idx=10 -> io_err=1 and stays high; all sums and counts unchanged; emitted centroids equal those of a run without that beat.
- Back-pressure: hold out_ready=0 for 20 cycles at beat idx2 -> valid stays high and idx/x/y stay stable; on release, handshake occurs and the next beat follows 65 cycles later.
- Flush with simultaneous beat: in_valid with (5.0,5.0) idx 7 in the same cycle as flush -> beat is included, idx7 outputs (5.0,5.0). After the pass, in_ready=1 and all counts are 0 (second flush emits 10 empty beats).
- Reset mid-pass: assert reset during DIV of idx4 -> next cycle out_valid=0, busy=0, in_ready=1, err=0. A subsequent flush emits all-empty beats.
